// File: rtl/ram_dma_arbiter.sv
// ram_dma_arbiter
//   Shares the single data-RAM write port between the core and N_REQ DMA
//   requesters (one per UART RX channel). The core always has priority. A
//   registered IDLE/WRITE sequencer latches a winner, then commits its write
//   in the first WRITE cycle where the core is not using the RAM.
//
//   Build option: define ARB_ROUND_ROBIN_EN for rotating priority (pointer
//   advances past each committed winner). Left undefined, the arbiter uses
//   fixed priority with the lowest index winning, and no pointer exists.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-low reset
//   cpu_access_i      core owns the RAM this cycle
//   req_i             per-requester write request (level, held until grant)
//   req_addr_i        flattened word addresses, requester k at [k*ADDR_W +: ADDR_W]
//   req_data_i        flattened write data, same packing
//   clr_err_i         per-requester pulse clearing its timeout flag
//   gnt_o             one-hot grant pulse in the commit cycle
//   ram_we_o          DMA-side RAM write enable
//   ram_addr_o        DMA-side RAM address (winner's slice)
//   ram_d_o           DMA-side RAM data (winner's slice)
//   sel_dma_o         RAM mux select, 1 = DMA drives the RAM
//   busy_o            sequencer in WRITE
//   err_o             sticky per-requester timeout flags

// Per-requester sticky timeout flag; set dominates clear.
module ram_dma_arbiter_err (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    output logic err
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   err <= 1'b0;
        else if (set) err <= 1'b1;
        else if (clr) err <= 1'b0;
    end
endmodule

module ram_dma_arbiter #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cpu_access_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    input  logic [N_REQ-1:0]          clr_err_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic                      ram_we_o,
    output logic [ADDR_W-1:0]         ram_addr_o,
    output logic [DATA_W-1:0]         ram_d_o,
    output logic                      sel_dma_o,
    output logic                      busy_o,
    output logic [N_REQ-1:0]          err_o
);
    localparam int         WIN_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_WRITE   = 1'b1;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [0:0]       state;
    logic [WIN_W-1:0] win;
    logic [WIN_W-1:0] pick;
    logic [15:0]      wait_cnt;
    logic             win_req;
    logic             commit;
    logic             blocked;
    logic [N_REQ-1:0] err_set;

    assign win_req = req_i[win];
    // Abandon is tested first: a dropped request never commits or blocks.
    assign commit  = (state == S_WRITE) && win_req && !cpu_access_i;
    assign blocked = (state == S_WRITE) && win_req &&  cpu_access_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic [WIN_W-1:0] ptr;
    logic             found;

    // First set request scanning upward from ptr, wrapping to 0.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[(int'(ptr) + i) % N_REQ]) begin
                pick  = WIN_W'((int'(ptr) + i) % N_REQ);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)      ptr <= '0;
        else if (commit) ptr <= (win == WIN_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
`else
    // Fixed priority: scanning downward leaves the lowest set index.
    always_comb begin
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) pick = WIN_W'(i);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            win      <= '0;
            wait_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (|req_i) begin
                win      <= pick;
                wait_cnt <= '0;
                state    <= S_WRITE;
            end
        end else begin
            if (!win_req || !cpu_access_i) begin
                state <= S_IDLE;
            end else if (wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    // Per-requester grant decode and timeout flags.
    for (genvar k = 0; k < N_REQ; k++) begin : g_req
        assign gnt_o[k]   = commit && (win == WIN_W'(k));
        // Fires once per wait: wait_cnt only passes TIMEOUT-1 going upward.
        assign err_set[k] = blocked && (wait_cnt == WAIT_LAST) && (win == WIN_W'(k));

        ram_dma_arbiter_err u_err (
            .clk   (clk_i),
            .rst_n (rst_i),
            .set   (err_set[k]),
            .clr   (clr_err_i[k]),
            .err   (err_o[k])
        );
    end

    assign ram_we_o   = commit;
    assign sel_dma_o  = commit;
    assign busy_o     = (state == S_WRITE);
    assign ram_addr_o = req_addr_i[int'(win)*ADDR_W +: ADDR_W];
    assign ram_d_o    = req_data_i[int'(win)*DATA_W +: DATA_W];

endmodule
